rf_wb_scheduler: RTL and testbench
==================================

# rf_wb_scheduler

Write-back scheduler for the 32x32 integer register file. It arbitrates two write-back requesters (single-cycle ALU path and multi-cycle LSU/MDU path) onto the register file's single write port (we3/a3/wd3). It keeps a pending-write scoreboard that the issue stage queries to stall on read-after-write hazards. It sits between the execute/memory units and the register file.

## Interface
Parameters:
- XLEN, 32, data width of write-back values
- NREG, 32, number of architectural registers (address width fixed at 5)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU write-back request
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  LSU/MDU write-back request
- mem_rd  in  5  LSU/MDU destination register
- mem_data  in  XLEN  LSU/MDU result
- mem_ready  out  1  LSU/MDU request accepted this cycle
- mark_en  in  1  issue stage marks a destination pending
- mark_rd  in  5  register to mark pending
- q_a1, q_a2  in  5 each  issue-stage source registers to check
- busy_a1, busy_a2  out  1 each  source register has a pending write
- wb_we  out  1  register-file write enable (drives we3)
- wb_addr  out  5  register-file write address (drives a3)
- wb_data  out  XLEN  register-file write data (drives wd3)
- sb_err  out  1  sticky: a write-back retired to a register not marked pending

## Operation
- Handshake: a transfer occurs on a requester when valid && ready in the same cycle. Requesters hold rd/data stable while valid && !ready.
- Arbitration (combinational ready): fixed priority, MEM over ALU. mem_ready = 1 whenever mem_valid. alu_ready = alu_valid && !mem_valid. A ready is never asserted without its valid.
- Accepted request is registered onto wb_we/wb_addr/wb_data for exactly one cycle. With no acceptance, wb_we=0 and wb_addr/wb_data hold their last values.
- rd = 0: the request is accepted (ready=1) but produces wb_we=0. The scoreboard is unaffected and sb_err is not raised.
- Scoreboard: busy[NREG-1:0], bit 0 hardwired 0.
  - mark_en with mark_rd≠0 sets busy[mark_rd] at the clock edge.
  - wb_we=1 clears busy[wb_addr] at the same edge the register file captures the data.
  - Same edge, same register, set and clear: set wins. A new producer is pending.
- busy_aN = busy[q_aN] (combinational). There is no forwarding; a register reads not-busy starting the cycle after its data is in the register file.
- sb_err sets at an edge where wb_we=1, wb_addr≠0 and busy[wb_addr]=0 (with no same-cycle mark of that address). It clears only on reset.
- State: per-requester FSM is not needed; the block state is {busy vector, output register, rr pointer (see Configuration), sb_err}.

## Timing
- Reset (rst=0 at posedge): wb_we=0, wb_addr=0, wb_data=0, busy=0, sb_err=0, rr pointer=ALU-favoured-next. While rst=0, alu_ready=mem_ready=0, busy_a1=busy_a2=0, and mark_en is ignored.
- Reset mid-operation discards any registered write (wb_we=0 the next cycle) and all pending marks.
- Latency: acceptance at edge N gives wb_we=1 in cycle N+1, the regfile write at edge N+1, and busy clear at edge N+1.
- Throughput: one write-back per cycle total. The losing requester stalls at least one cycle.
- Both valid every cycle: under fixed priority, ALU starves until mem_valid drops.

## Configuration
- RF_WB_RR_EN defined: round-robin arbitration. A 1-bit pointer selects which requester wins a conflict; after any cycle in which both are valid, the winner becomes lowest priority. With a single valid requester, that requester always wins and the pointer still updates to favour the other. No requester waits more than 1 cycle under continuous contention.
- RF_WB_RR_EN undefined: fixed MEM-over-ALU priority as above. The pointer logic is absent.

## Test plan
- Reset: hold rst=0 three cycles with alu_valid=1 and mark_en=1 → wb_we=0, ready=0, busy_a*=0, sb_err=0 throughout.
- Single write:
  - Stimulus: mark x5 at cycle 0, then alu_valid with rd=5, data=0xDEADBEEF at cycle 2.
  - Required: alu_ready=1 in cycle 2, wb_we=1/wb_addr=5/wb_data=0xDEADBEEF in cycle 3, busy_a1 (q_a1=5) is 1 in cycles 1–3 and 0 in cycle 4.
- Contention:
  - Stimulus: alu_valid (rd=3) and mem_valid (rd=4) both held.
  - Required, fixed priority: writes x4 first, ALU stalls until mem_valid drops.
  - Required, RF_WB_RR_EN: grants alternate 4,3,4,3 when requests are re-presented each cycle.
- x0 handling: mem_valid with rd=0, data=0x1 → mem_ready=1, wb_we stays 0, sb_err stays 0. Marking x0 leaves busy_a1 (q_a1=0) at 0.
- Set/clear collision: x7 pending, write-back of x7 retires in the same cycle mark_en marks x7 → busy[7] remains 1 afterwards. A later second write-back to x7 clears it.
- Scoreboard error: write-back to x9 with no prior mark → sb_err=1 the cycle after wb_we. It stays 1 until rst=0.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Write-back arbiter and pending-write scoreboard for the 32x32 register file.
// Define RF_WB_RR_EN for round-robin arbitration (default: MEM over ALU).
module rf_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            mark_en,
  input  logic [4:0]      mark_rd,
  input  logic [4:0]      q_a1,
  input  logic [4:0]      q_a2,
  output logic            busy_a1,
  output logic            busy_a2,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            sb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            sb_err_q, sb_err_d;
  logic [31:0]     busy_ext, busy_nx;
  logic            acc;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;

`ifdef RF_WB_RR_EN
  logic rr_alu_q, rr_alu_d;

  // rr_alu_q=1: ALU wins the next conflict
  assign mem_ready = rst && mem_valid
                     && (!alu_valid || !rr_alu_q);
  assign alu_ready = rst && alu_valid
                     && (!mem_valid || rr_alu_q);

  always_comb begin
    rr_alu_d = rr_alu_q;
    if (mem_ready)      rr_alu_d = 1'b1;
    else if (alu_ready) rr_alu_d = 1'b0;
  end
`else
  assign mem_ready = rst && mem_valid;
  assign alu_ready = rst && alu_valid && !mem_valid;
`endif

  assign acc      = mem_ready || alu_ready;
  assign acc_rd   = mem_ready ? mem_rd : alu_rd;
  assign acc_data = mem_ready ? mem_data : alu_data;
  assign busy_ext = 32'(busy_q);

  always_comb begin
    wb_we_d   = acc && (acc_rd != 5'd0);
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (acc) begin
      wb_addr_d = acc_rd;
      wb_data_d = acc_data;
    end
  end

  // Retire clears, then a same-edge mark re-sets
  always_comb begin
    busy_nx = busy_ext;
    if (wb_we_q) busy_nx[wb_addr_q] = 1'b0;
    if (mark_en && mark_rd != 5'd0)
      busy_nx[mark_rd] = 1'b1;
    busy_nx[0] = 1'b0;
    busy_d = busy_nx[NREG-1:0];
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (wb_we_q && wb_addr_q != 5'd0
        && !busy_ext[wb_addr_q]
        && !(mark_en && mark_rd == wb_addr_q))
      sb_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q    <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
      sb_err_q  <= 1'b0;
`ifdef RF_WB_RR_EN
      rr_alu_q  <= 1'b1;
`endif
    end else begin
      busy_q    <= busy_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      sb_err_q  <= sb_err_d;
`ifdef RF_WB_RR_EN
      rr_alu_q  <= rr_alu_d;
`endif
    end
  end

  assign busy_a1 = rst && busy_ext[q_a1];
  assign busy_a2 = rst && busy_ext[q_a2];
  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign sb_err  = sb_err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus a randomized run
// against a pending-set reference model.
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, mark_en;
  logic [4:0]  alu_rd, mem_rd, mark_rd, q_a1, q_a2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, busy_a1, busy_a2;
  logic        wb_we, sb_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  bit          pend[32];
  bit          m_we, m_err, m_fav_alu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  rf_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .mark_en(mark_en), .mark_rd(mark_rd),
    .q_a1(q_a1), .q_a2(q_a2),
    .busy_a1(busy_a1), .busy_a2(busy_a2),
    .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic void model_grant(output bit ga, output bit gm);
    ga = 0;
    gm = 0;
    if (rst) begin
      if (alu_valid && mem_valid) begin
`ifdef RF_WB_RR_EN
        ga = m_fav_alu;
        gm = !m_fav_alu;
`else
        gm = 1;
`endif
      end else begin
        ga = alu_valid;
        gm = mem_valid;
      end
    end
  endfunction

  task automatic tick();
    bit ga, gm;
    @(posedge clk);
    model_grant(ga, gm);
    if (!rst) begin
      foreach (pend[i]) pend[i] = 0;
      m_we = 0; m_err = 0; m_fav_alu = 1;
      m_addr = 0; m_data = 0;
    end else begin
      if (m_we) begin
        if (m_addr != 0 && !pend[m_addr]
            && !(mark_en && mark_rd == m_addr))
          m_err = 1;
        pend[m_addr] = 0;
      end
      if (mark_en && mark_rd != 0) pend[mark_rd] = 1;
      m_we = 0;
      if (gm || ga) begin
        m_addr = gm ? mem_rd : alu_rd;
        m_data = gm ? mem_data : alu_data;
        m_we = (m_addr != 0);
        m_fav_alu = gm;
      end
    end
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; mark_en = 0;
    alu_rd = 0; mem_rd = 0; mark_rd = 0;
    alu_data = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    alu_valid = 1; alu_rd = 5; mem_valid = 1; mem_rd = 6;
    mark_en = 1; mark_rd = 5; q_a1 = 5; q_a2 = 6;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if ({wb_we, alu_ready, mem_ready, busy_a1, busy_a2, sb_err}
          !== 6'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: we=%b ar=%b mr=%b b1=%b b2=%b err=%b want all 0",
                 i, wb_we, alu_ready, mem_ready, busy_a1, busy_a2, sb_err);
      end
    end
    idle();
    rst = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    q_a1 = 5;
    mark_en = 1; mark_rd = 5;
    #1;
    checks++;
    if (busy_a1 !== 1'b0) begin
      errors++;
      $display("FAIL single busy_c0: got %b want 0", busy_a1);
    end
    tick();
    mark_en = 0;
    #1;
    checks++;
    if (busy_a1 !== 1'b1) begin
      errors++;
      $display("FAIL single busy_c1: got %b want 1", busy_a1);
    end
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || busy_a1 !== 1'b1) begin
      errors++;
      $display("FAIL single c2: ready=%b busy=%b want 1 1", alu_ready, busy_a1);
    end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd5
        || wb_data !== 32'hDEADBEEF || busy_a1 !== 1'b1) begin
      errors++;
      $display("FAIL single c3: we=%b addr=%0d data=%h busy=%b want 1 5 deadbeef 1",
               wb_we, wb_addr, wb_data, busy_a1);
    end
    tick();
    #1;
    checks++;
    if (busy_a1 !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL single c4: busy=%b we=%b want 0 0", busy_a1, wb_we);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp_seq [4];
`ifdef RF_WB_RR_EN
    exp_seq = '{5'd4, 5'd3, 5'd4, 5'd3};
`else
    exp_seq = '{5'd4, 5'd4, 5'd4, 5'd4};
`endif
    do_reset();
    alu_valid = 1; alu_rd = 0;
    tick();
    alu_rd = 3; alu_data = 32'h33;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_ready !== (exp_seq[i] == 5'd4)
          || alu_ready !== (exp_seq[i] == 5'd3)) begin
        errors++;
        $display("FAIL contend ready%0d: mr=%b ar=%b want grant x%0d",
                 i, mem_ready, alu_ready, exp_seq[i]);
      end
      tick();
      #1;
      checks++;
      if (wb_we !== 1'b1 || wb_addr !== exp_seq[i]) begin
        errors++;
        $display("FAIL contend wb%0d: we=%b addr=%0d want 1 %0d",
                 i, wb_we, wb_addr, exp_seq[i]);
      end
    end
    mem_valid = 0;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL contend drop: alu_ready=%b want 1", alu_ready);
    end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'h33) begin
      errors++;
      $display("FAIL contend alu: we=%b addr=%0d data=%h want 1 3 33",
               wb_we, wb_addr, wb_data);
    end
  endtask

  task automatic test_x0();
    do_reset();
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0 ready: got %b want 1", mem_ready);
    end
    tick();
    mem_valid = 0;
    mark_en = 1; mark_rd = 0; q_a1 = 0;
    #1;
    checks++;
    if (wb_we !== 1'b0 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL x0 wb: we=%b err=%b want 0 0", wb_we, sb_err);
    end
    tick();
    mark_en = 0;
    #1;
    checks++;
    if (busy_a1 !== 1'b0 || sb_err !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL x0 mark: busy=%b err=%b we=%b want 0 0 0",
               busy_a1, sb_err, wb_we);
    end
  endtask

  task automatic test_collision();
    do_reset();
    q_a1 = 7;
    mark_en = 1; mark_rd = 7;
    tick();
    mark_en = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    mark_en = 1; mark_rd = 7;
    #1;
    checks++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd7) begin
      errors++;
      $display("FAIL collide wb: we=%b addr=%0d want 1 7", wb_we, wb_addr);
    end
    tick();
    mark_en = 0;
    #1;
    checks++;
    if (busy_a1 !== 1'b1 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL collide keep: busy=%b err=%b want 1 0", busy_a1, sb_err);
    end
    alu_valid = 1; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    tick();
    #1;
    checks++;
    if (busy_a1 !== 1'b0 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL collide clear: busy=%b err=%b want 0 0", busy_a1, sb_err);
    end
  endtask

  task automatic test_sberr();
    do_reset();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if (wb_we !== 1'b1 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL sberr wb: we=%b err=%b want 1 0", wb_we, sb_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (sb_err !== 1'b1) begin
        errors++;
        $display("FAIL sberr sticky%0d: got %b want 1", i, sb_err);
      end
    end
    rst = 0;
    tick();
    rst = 1;
    #1;
    checks++;
    if (sb_err !== 1'b0) begin
      errors++;
      $display("FAIL sberr reset: got %b want 0", sb_err);
    end
  endtask

  task automatic test_random();
    bit ga, gm, hold_a, hold_m;
    do_reset();
    hold_a = 0;
    hold_m = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) != 0);
      if (!hold_a) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!hold_m) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_rd = 5'($urandom_range(0, 7));
        mem_data = $urandom;
      end
      mark_en = ($urandom_range(0, 1) != 0);
      mark_rd = 5'($urandom_range(0, 7));
      q_a1 = 5'($urandom_range(0, 8));
      q_a2 = 5'($urandom_range(0, 8));
      #1;
      model_grant(ga, gm);
      checks++;
      if (alu_ready !== ga || mem_ready !== gm) begin
        errors++;
        $display("FAIL rand ready c%0d: ar=%b mr=%b want %b %b",
                 c, alu_ready, mem_ready, ga, gm);
      end
      checks++;
      if (busy_a1 !== (rst && pend[q_a1])
          || busy_a2 !== (rst && pend[q_a2])) begin
        errors++;
        $display("FAIL rand busy c%0d: b1=%b b2=%b want %b %b", c,
                 busy_a1, busy_a2, rst && pend[q_a1], rst && pend[q_a2]);
      end
      checks++;
      if (wb_we !== m_we || sb_err !== m_err
          || (m_we && (wb_addr !== m_addr || wb_data !== m_data))) begin
        errors++;
        $display("FAIL rand wb c%0d: we=%b a=%0d d=%h err=%b want %b %0d %h %b",
                 c, wb_we, wb_addr, wb_data, sb_err,
                 m_we, m_addr, m_data, m_err);
      end
      hold_a = rst && alu_valid && !ga;
      hold_m = rst && mem_valid && !gm;
      tick();
    end
    idle();
    rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    q_a1 = 0;
    q_a2 = 0;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_collision();
    test_sberr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
